pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised EX->MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
//  The upstream ALU can keep issuing while MEM stalls; one extra instruction is absorbed before backpressure.
//  Adds per-stage flush, global freeze and an occupancy count.
//  Control outputs are gated by valid, so a drained stage never issues spurious writes.
// PARAMETERS
//  LEN     32  width of pc, instruction, alu_result and src2_val
//  DEST_W  5   width of destination register index
// PORTS
//  clock            in   1       rising-edge clock
//  reset            in   1       asynchronous, active-high reset
//  flush            in   1       synchronous kill of all held entries
//  freez            in   1       global stall; holds every state and register
//  in_valid         in   1       upstream has an instruction
//  in_ready         out  1       stage can accept an instruction this cycle
//  in_ctrl          in   3       {wb_en, mem_write, mem_read}
//  in_pc            in   LEN     instruction PC
//  in_instruction   in   LEN     instruction word
//  in_alu_result    in   LEN     ALU result / memory address
//  in_src2_val      in   LEN     store data
//  in_dest          in   DEST_W  destination register
//  out_valid        out  1       head entry present
//  out_ready        in   1       downstream consumes the head entry
//  out_wb_en        out  1       head wb_en & out_valid
//  out_mem_write    out  1       head mem_write & out_valid
//  out_mem_read     out  1       head mem_read & out_valid
//  out_pc           out  LEN     head PC
//  out_instruction  out  LEN     head instruction
//  out_alu_result   out  LEN     head ALU result
//  out_src2_val     out  LEN     head store data
//  out_dest         out  DEST_W  head destination
//  count            out  2       occupancy, 0..2
// BEHAVIOUR
//  - Storage: head register H (drives out_*), skid register S.
//    States: EMPTY(count=0), ONE(H valid, count=1), FULL(H and S valid, count=2).
//  - Handshake signals:
//    in_ready  = (state!=FULL) & ~freez & ~flush
//    acc       = in_valid & in_ready
//    out_valid = (state!=EMPTY)
//    fire      = out_valid & out_ready & ~freez & ~flush
//  - Transitions:
//    EMPTY: acc -> ONE, H<=in.
//    ONE:   acc&fire -> ONE, H<=in;  acc&~fire -> FULL, S<=in;  fire&~acc -> EMPTY.
//    FULL:  fire -> ONE, H<=S.  No accept is possible while FULL.
//  - No combinational path from in_* to out_*; in->out latency is exactly 1 cycle when the stage is EMPTY or ONE-and-firing.
//  - Order is preserved: the S entry always leaves after the H entry.
//  - freez=1: no state or data change. in_ready=0. out_valid and out_* hold their values, but no fire occurs.
//  - flush=1 (priority over freez and all handshakes): next state EMPTY, H and S payloads cleared to 0, the in_* beat that cycle is dropped.
//  - Draining to EMPTY via fire: H payload is kept, but out_wb_en, out_mem_write and out_mem_read read 0 through valid gating.
//  - Reset (async, any cycle incl. mid-transfer): state EMPTY, count=0, out_valid=0, in_ready=1.
//    All out_* data and control outputs read 0.
//  - No arithmetic on the payload; widths pass through unchanged.
// TESTING
//  T1 single beat: EMPTY, in_valid=1, pc=0x10, alu=0x40, ctrl=3'b100, out_ready=1
//     -> next cycle out_valid=1, out_pc=0x10, out_wb_en=1, count=1; one cycle later count=0.
//  T2 skid: out_ready=0, send A(pc=4) then B(pc=8)
//     -> count=2, in_ready=0, out_pc=4; raise out_ready -> A leaves, then B (out_pc=8), in_ready=1 the cycle after A fires.
//  T3 back-to-back: out_ready=1, in_valid=1 every cycle, pc=0,4,8,..
//     -> count stays 1, one beat per cycle, out_pc lags in_pc by 1.
//  T4 freeze: FULL, assert freez 3 cycles with out_ready=1
//     -> count=2, out_pc unchanged, in_ready=0; release -> drain resumes in order.
//  T5 flush: FULL, flush=1 together with in_valid=1, freez=1
//     -> next cycle count=0, out_valid=0, out_mem_write=0, new beat dropped.
//  T6 reset: assert reset asynchronously mid-cycle while FULL
//     -> immediately count=0, out_valid=0, all out_* read 0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// EX->MEM pipeline stage with valid/ready handshake and a two-entry skid buffer.
// Head register drives the outputs; the skid register absorbs one beat while MEM stalls.
module pipe_stage_skid #(
    parameter int LEN    = 32,
    parameter int DEST_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              freez,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_ctrl,
    input  logic [LEN-1:0]    in_pc,
    input  logic [LEN-1:0]    in_instruction,
    input  logic [LEN-1:0]    in_alu_result,
    input  logic [LEN-1:0]    in_src2_val,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_write,
    output logic              out_mem_read,
    output logic [LEN-1:0]    out_pc,
    output logic [LEN-1:0]    out_instruction,
    output logic [LEN-1:0]    out_alu_result,
    output logic [LEN-1:0]    out_src2_val,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        count
);

    typedef struct packed {
        logic [2:0]        ctrl;
        logic [LEN-1:0]    pc;
        logic [LEN-1:0]    instruction;
        logic [LEN-1:0]    alu_result;
        logic [LEN-1:0]    src2_val;
        logic [DEST_W-1:0] dest;
    } entry_t;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t in_entry;
    logic   acc;
    logic   fire;

    assign in_entry = '{ctrl: in_ctrl, pc: in_pc, instruction: in_instruction,
                        alu_result: in_alu_result, src2_val: in_src2_val, dest: in_dest};

    assign in_ready  = (state != FULL) && !freez && !flush;
    assign acc       = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign fire      = out_valid && out_ready && !freez && !flush;
    assign count     = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            // freez is folded into acc/fire, so a frozen cycle changes nothing here.
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        head  <= in_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acc && fire) begin
                        head <= in_entry;
                    end else if (acc) begin
                        skid  <= in_entry;
                        state <= FULL;
                    end else if (fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Control bits are gated so a drained stage cannot trigger writes downstream.
    assign out_wb_en       = head.ctrl[2] && out_valid;
    assign out_mem_write   = head.ctrl[1] && out_valid;
    assign out_mem_read    = head.ctrl[0] && out_valid;
    assign out_pc          = head.pc;
    assign out_instruction = head.instruction;
    assign out_alu_result  = head.alu_result;
    assign out_src2_val    = head.src2_val;
    assign out_dest        = head.dest;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed beats are queued when accepted and
// popped by an independent monitor whenever the stage hands a beat downstream.
module tb_pipe_stage_skid;

    localparam int LEN    = 32;
    localparam int DEST_W = 5;

    typedef struct {
        logic [2:0]        ctrl;
        logic [LEN-1:0]    pc;
        logic [LEN-1:0]    instruction;
        logic [LEN-1:0]    alu_result;
        logic [LEN-1:0]    src2_val;
        logic [DEST_W-1:0] dest;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              freez = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_ctrl = '0;
    logic [LEN-1:0]    in_pc = '0;
    logic [LEN-1:0]    in_instruction = '0;
    logic [LEN-1:0]    in_alu_result = '0;
    logic [LEN-1:0]    in_src2_val = '0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_wb_en;
    logic              out_mem_write;
    logic              out_mem_read;
    logic [LEN-1:0]    out_pc;
    logic [LEN-1:0]    out_instruction;
    logic [LEN-1:0]    out_alu_result;
    logic [LEN-1:0]    out_src2_val;
    logic [DEST_W-1:0] out_dest;
    logic [1:0]        count;

    int    tests = 0;
    int    fails = 0;
    beat_t sb[$];

    pipe_stage_skid #(.LEN(LEN), .DEST_W(DEST_W)) dut (
        .clock(clock), .reset(reset), .flush(flush), .freez(freez),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_pc(in_pc), .in_instruction(in_instruction), .in_alu_result(in_alu_result),
        .in_src2_val(in_src2_val), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_en(out_wb_en), .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_pc(out_pc), .out_instruction(out_instruction), .out_alu_result(out_alu_result),
        .out_src2_val(out_src2_val), .out_dest(out_dest), .count(count)
    );

    always #5 clock = ~clock;

    // Payload fields are fixed functions of the pc so each beat is recognisable.
    function automatic beat_t makeBeat(input logic [LEN-1:0] pc, input logic [2:0] ctrl);
        beat_t b;
        b.ctrl        = ctrl;
        b.pc          = pc;
        b.instruction = {pc[15:0], 16'hA5C3};
        b.alu_result  = pc << 2;
        b.src2_val    = ~pc;
        b.dest        = pc[6:2];
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus; the beat is queued only if the stage accepts it.
    task automatic applyStimulus(input logic v, input logic [LEN-1:0] pc, input logic [2:0] ctrl,
                                 input logic rdy, input logic fz, input logic fl);
        beat_t b;
        @(posedge clock);
        #1;
        b          = makeBeat(pc, ctrl);
        in_valid   = v;
        in_ctrl    = b.ctrl;
        in_pc      = b.pc;
        in_instruction = b.instruction;
        in_alu_result  = b.alu_result;
        in_src2_val    = b.src2_val;
        in_dest    = b.dest;
        out_ready  = rdy;
        freez      = fz;
        flush      = fl;
        #1;
        if (fl) sb.delete();
        else if (v && in_ready) sb.push_back(b);
    endtask

    // Monitor: compares the head entry against the scoreboard on every hand-off.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready && !freez && !flush) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_beat: got pc 0x%0h, expected no beat", out_pc);
            end else begin
                beat_t e;
                e = sb.pop_front();
                checkOutput("mon_pc", out_pc, e.pc);
                checkOutput("mon_instr", out_instruction, e.instruction);
                checkOutput("mon_alu", out_alu_result, e.alu_result);
                checkOutput("mon_src2", out_src2_val, e.src2_val);
                checkOutput("mon_dest", 32'(out_dest), 32'(e.dest));
                checkOutput("mon_ctrl", 32'({out_wb_en, out_mem_write, out_mem_read}), 32'(e.ctrl));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // T1 single beat
        applyStimulus(1, 32'h10, 3'b100, 1, 0, 0);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_pc", out_pc, 32'h10);
        checkOutput("t1_alu", out_alu_result, 32'h40);
        checkOutput("t1_wb_en", 32'(out_wb_en), 32'd1);
        checkOutput("t1_count", 32'(count), 32'd1);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t1_count_drained", 32'(count), 32'd0);
        checkOutput("t1_wb_en_gated", 32'(out_wb_en), 32'd0);
        checkOutput("t1_pc_kept", out_pc, 32'h10);

        // T2 skid absorbs a second beat
        applyStimulus(1, 32'h4, 3'b010, 0, 0, 0);
        applyStimulus(1, 32'h8, 3'b001, 0, 0, 0);
        checkOutput("t2_count_one", 32'(count), 32'd1);
        applyStimulus(0, 32'h0, 3'b000, 0, 0, 0);
        checkOutput("t2_count_full", 32'(count), 32'd2);
        checkOutput("t2_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t2_pc_a", out_pc, 32'h4);
        checkOutput("t2_mem_write", 32'(out_mem_write), 32'd1);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t2_pc_b", out_pc, 32'h8);
        checkOutput("t2_in_ready_after", 32'(in_ready), 32'd1);
        checkOutput("t2_mem_read", 32'(out_mem_read), 32'd1);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t2_count_empty", 32'(count), 32'd0);

        // T3 back-to-back streaming
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'(4 * i), 3'b100, 1, 0, 0);
            if (i >= 1) begin
                checkOutput("t3_count", 32'(count), 32'd1);
                checkOutput("t3_pc_lag", out_pc, 32'(4 * (i - 1)));
            end
        end
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t3_last_pc", out_pc, 32'd28);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t3_count_empty", 32'(count), 32'd0);

        // T4 freeze while full, with a competing input beat
        applyStimulus(1, 32'h100, 3'b110, 0, 0, 0);
        applyStimulus(1, 32'h104, 3'b001, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h200, 3'b111, 1, 1, 0);
            checkOutput("t4_count", 32'(count), 32'd2);
            checkOutput("t4_pc", out_pc, 32'h100);
            checkOutput("t4_in_ready", 32'(in_ready), 32'd0);
            checkOutput("t4_valid", 32'(out_valid), 32'd1);
        end
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t4_release_pc", out_pc, 32'h100);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t4_second_pc", out_pc, 32'h104);
        checkOutput("t4_second_count", 32'(count), 32'd1);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("t4_count_empty", 32'(count), 32'd0);

        // T5 flush beats freeze and drops the incoming beat
        applyStimulus(1, 32'h300, 3'b010, 0, 0, 0);
        applyStimulus(1, 32'h304, 3'b010, 0, 0, 0);
        applyStimulus(1, 32'h308, 3'b010, 1, 1, 1);
        checkOutput("t5_pre_count", 32'(count), 32'd2);
        applyStimulus(0, 32'h0, 3'b000, 0, 0, 0);
        checkOutput("t5_count", 32'(count), 32'd0);
        checkOutput("t5_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_mem_write", 32'(out_mem_write), 32'd0);
        checkOutput("t5_pc_cleared", out_pc, 32'h0);
        applyStimulus(0, 32'h0, 3'b000, 0, 0, 0);
        checkOutput("t5_dropped", 32'(count), 32'd0);

        // T6 asynchronous reset mid-cycle while full
        applyStimulus(1, 32'h400, 3'b111, 0, 0, 0);
        applyStimulus(1, 32'h404, 3'b111, 0, 0, 0);
        applyStimulus(0, 32'h0, 3'b000, 0, 0, 0);
        checkOutput("t6_pre_count", 32'(count), 32'd2);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        checkOutput("t6_count", 32'(count), 32'd0);
        checkOutput("t6_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_pc", out_pc, 32'h0);
        checkOutput("t6_alu", out_alu_result, 32'h0);
        checkOutput("t6_src2", out_src2_val, 32'h0);
        checkOutput("t6_dest", 32'(out_dest), 32'd0);
        checkOutput("t6_ctrl", 32'({out_wb_en, out_mem_write, out_mem_read}), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Stage works normally after reset
        applyStimulus(1, 32'h500, 3'b101, 1, 0, 0);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("post_pc", out_pc, 32'h500);
        checkOutput("post_count", 32'(count), 32'd1);
        applyStimulus(0, 32'h0, 3'b000, 1, 0, 0);
        checkOutput("post_count_empty", 32'(count), 32'd0);
        @(negedge clock);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
